// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//   Multiplexed seven-segment display driver. A packed BCD word plus one
//   decimal point per digit is accepted over a valid/ready handshake into a
//   pending buffer. It is copied into the active (displayed) buffer only at a
//   frame boundary, so a frame never mixes old and new digits. Digits are lit
//   one at a time, each preceded by an optional dark gap that suppresses
//   ghosting on the shared segment bus.
//
// Optional feature (compile-time macro LZ_BLANK_EN):
//   When defined, zero digits above the most significant nonzero digit are
//   blanked (seg_out = 0). digit_en still cycles, dp is still shown, and
//   digit 0 is never blanked. When undefined, every digit is decoded as-is.
//
// Parameters
//   NUM_DIGITS    digits scanned, index 0 = least significant
//   DWELL_CYCLES  clk cycles each digit is lit (>= 1)
//   BLANK_CYCLES  dark clk cycles before each digit (0 = no gap)
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   load_valid  load_bcd/load_dp are valid
//   load_ready  pending buffer is empty; load accepted when valid & ready
//   load_bcd    digit i = load_bcd[4i+3:4i]
//   load_dp     decimal point per digit
//   seg_out     active-high segments, [0]=a ... [6]=g
//   dp_out      decimal point of the lit digit
//   digit_en    one-hot digit select, all zero while dark
//   frame_done  one-cycle pulse in the last cycle of the last digit's dwell
// ---------------------------------------------------------------------------
module seg7_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 250,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  // Unused when there is no gap (BLANK is then never entered).
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // With no gap the scan starts directly on digit 0.
  localparam state_t ST_RESET = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;

  logic [4*NUM_DIGITS-1:0] active_bcd_reg;
  logic [NUM_DIGITS-1:0]   active_dp_reg;
  logic [4*NUM_DIGITS-1:0] pending_bcd_reg;
  logic [NUM_DIGITS-1:0]   pending_dp_reg;
  logic                    pending_full_reg;

  logic                    lit;
  logic [6:0]              digit_seg [NUM_DIGITS];

  // Values 10-15 are not BCD and render dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Scan FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    case (state_reg)
      ST_BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          cnt_next   = '0;
          state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_reg == DWELL_LAST) begin
          cnt_next   = '0;
          idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
          state_next = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_RESET;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, buffers and handshake
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_RESET;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      active_bcd_reg   <= '0;
      active_dp_reg    <= '0;
      pending_bcd_reg  <= '0;
      pending_dp_reg   <= '0;
      pending_full_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      // Commit needs pending_full and accept needs it clear, so the two
      // are mutually exclusive. A load accepted in the frame_done cycle
      // waits for the following boundary.
      if (frame_done && pending_full_reg) begin
        active_bcd_reg   <= pending_bcd_reg;
        active_dp_reg    <= pending_dp_reg;
        pending_full_reg <= 1'b0;
      end else if (load_valid && !pending_full_reg) begin
        pending_bcd_reg  <= load_bcd;
        pending_dp_reg   <= load_dp;
        pending_full_reg <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-digit segment patterns from the active buffer
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] digit_val;
    assign digit_val = active_bcd_reg[4*gi +: 4];
`ifdef LZ_BLANK_EN
    if (gi == 0) begin : g_lsd
      assign digit_seg[gi] = seg_decode(digit_val);
    end else begin : g_upper
      // Blank when this digit and everything above it are zero.
      logic upper_zero;
      assign upper_zero    = (active_bcd_reg[4*NUM_DIGITS-1:4*gi] == '0);
      assign digit_seg[gi] = upper_zero ? 7'h00 : seg_decode(digit_val);
    end
`else
    assign digit_seg[gi] = seg_decode(digit_val);
`endif
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registers only
  // -------------------------------------------------------------------------
  assign lit        = (state_reg == ST_SHOW);
  assign load_ready = !pending_full_reg;
  assign frame_done = lit && (idx_reg == IDX_LAST) && (cnt_reg == DWELL_LAST);

  always_comb begin
    digit_en = '0;
    seg_out  = 7'h00;
    dp_out   = 1'b0;
    if (lit) begin
      digit_en[idx_reg] = 1'b1;
      seg_out           = digit_seg[idx_reg];
      dp_out            = active_dp_reg[idx_reg];
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_mux
//   Randomised plus directed bench for seg7_scan_mux (4 digits, dwell 4,
//   gap 2). A reference model derives every expected output from the cycle
//   count since reset (slot = count mod period) and from the displayed and
//   pending words, which it updates with the load and commit rules.
//   Outputs are sampled on the falling edge. Build with +define+LZ_BLANK_EN
//   to check the leading-zero build.
// ---------------------------------------------------------------------------
module tb_seg7_scan_mux;

  localparam int ND     = 4;
  localparam int DW     = 4;
  localparam int BL     = 2;
  localparam int SLOT   = DW + BL;
  localparam int PERIOD = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_bcd;
  logic [3:0]  load_dp;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_t = 0;
  logic [15:0] m_act_bcd  = '0;
  logic [3:0]  m_act_dp   = '0;
  logic [15:0] m_pend_bcd = '0;
  logic [3:0]  m_pend_dp  = '0;
  bit          m_pend_full = 1'b0;
  bit          m_accepted  = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS  (ND),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_bcd  (load_bcd),
    .load_dp   (load_dp),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [15:0] word, input int d);
    int v;
    v = int'((word >> (4 * d)) & 16'hF);
    if (v > 9) return 7'h00;
`ifdef LZ_BLANK_EN
    if (d > 0 && (word >> (4 * d)) == 16'h0) return 7'h00;
`endif
    return seg_tab[v];
  endfunction

  task automatic check_outputs();
    int pos, d, ph;
    bit lit;
    pos = m_t % PERIOD;
    d   = pos / SLOT;
    ph  = pos % SLOT;
    lit = (ph >= BL);
    chk("digit_en",   32'(digit_en),   lit ? (32'd1 << d) : 32'd0);
    chk("seg_out",    32'(seg_out),    lit ? 32'(exp_seg(m_act_bcd, d)) : 32'd0);
    chk("dp_out",     32'(dp_out),     lit ? 32'(m_act_dp[d]) : 32'd0);
    chk("frame_done", 32'(frame_done), 32'(pos == PERIOD - 1));
    chk("load_ready", 32'(load_ready), 32'(!m_pend_full));
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit fd, acc;
    m_accepted = 1'b0;
    if (rst) begin
      m_t         = 0;
      m_act_bcd   = '0;
      m_act_dp    = '0;
      m_pend_bcd  = '0;
      m_pend_dp   = '0;
      m_pend_full = 1'b0;
    end else begin
      fd  = ((m_t % PERIOD) == PERIOD - 1);
      acc = load_valid && !m_pend_full;
      if (fd && m_pend_full) begin
        m_act_bcd   = m_pend_bcd;
        m_act_dp    = m_pend_dp;
        m_pend_full = 1'b0;
      end
      if (acc) begin
        m_pend_bcd  = load_bcd;
        m_pend_dp   = load_dp;
        m_pend_full = 1'b1;
        m_accepted  = 1'b1;
        $display("load accepted bcd=%h dp=%b t=%0d", load_bcd, load_dp, m_t);
      end
      m_t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present a word and hold it until accepted (bounded).
  task automatic send(input logic [15:0] bcd, input logic [3:0] dp);
    bit done;
    done       = 1'b0;
    load_valid = 1'b1;
    load_bcd   = bcd;
    load_dp    = dp;
    for (int i = 0; i < 4 * PERIOD && !done; i++) begin
      tick();
      done = m_accepted;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    load_valid = 1'b0;
  endtask

  // Advance until the model is at the given slot of the frame (bounded).
  task automatic wait_pos(input int p);
    bit hit;
    hit = ((m_t % PERIOD) == p);
    for (int i = 0; i < 2 * PERIOD && !hit; i++) begin
      tick();
      hit = ((m_t % PERIOD) == p);
    end
    if (!hit) chk("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_bcd   = '0;
    load_dp    = '0;

    // Reset for three cycles, then a full frame of the reset contents.
    run(3);
    rst = 1'b0;
    run(PERIOD + 6);

    // Mid-frame load: current frame unchanged, next frame shows it.
    wait_pos(10);
    send(16'h1234, 4'b0100);
    run(2 * PERIOD);

    // Back-to-back loads: the second waits for the frame boundary.
    wait_pos(5);
    send(16'h5678, 4'b0001);
    send(16'h9012, 4'b1000);
    run(2 * PERIOD);

    // Non-BCD digit value renders dark while still selected.
    send(16'h3A21, 4'b0010);
    run(2 * PERIOD);

    // Leading zeros, and an all-zero word (digit 0 always shown).
    send(16'h0050, 4'b0000);
    run(2 * PERIOD);
    send(16'h0000, 4'b1111);
    run(2 * PERIOD);

    // Reset during SHOW with pending data: the pending word is discarded.
    wait_pos(1);
    send(16'h4321, 4'hF);
    chk("pending_before_rst", 32'(load_ready), 32'd0);
    chk("show_before_rst", 32'(digit_en != 4'b0), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(2 * PERIOD);

    // Random words with random idle gaps; junk data while not valid.
    for (int n = 0; n < 24; n++) begin
      int gap;
      gap = $urandom_range(0, 40);
      for (int g = 0; g < gap; g++) begin
        load_bcd = 16'($urandom);
        load_dp  = 4'($urandom);
        tick();
      end
      send(16'($urandom), 4'($urandom));
    end
    run(3 * PERIOD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0d)", m_t);
    $fatal(1, "watchdog expired");
  end

endmodule
